// File: rtl/ram_burst_ctrl_pkg.sv
// Shared types and constants for the RAM burst controller.
// Holds the controller FSM states and the read-buffer geometry.
package ram_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/burst_rd_fifo.sv
// Two-entry read-data buffer between the RAM return path and the read stream.
// Head entry is presented combinationally; a pop on an empty buffer is ignored.
module burst_rd_fifo
  import ram_burst_ctrl_pkg::*;
#(
  parameter int SIZE_DATA = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [SIZE_DATA-1:0]  i_data,
  input  logic                  i_pop,
  output logic [SIZE_DATA-1:0]  o_data,
  output logic                  o_valid,
  output logic [FIFO_CNT_W-1:0] o_count
);

  logic [SIZE_DATA-1:0]  r_mem [FIFO_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [FIFO_CNT_W-1:0] r_count;
  logic                  w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + FIFO_CNT_W'(i_push) - FIFO_CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller: turns a single start-address/length command into a stream
// of RAM writes or reads, buffering read returns in a 2-entry FIFO.
module ram_burst_ctrl
  import ram_burst_ctrl_pkg::*;
#(
  parameter int SIZE_ADDR = 8,
  parameter int SIZE_DATA = 8,
  parameter int SIZE_LEN  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_wr,
  input  logic [SIZE_ADDR-1:0] i_cmd_addr,
  input  logic [SIZE_LEN-1:0]  i_cmd_len,
  input  logic                 i_wdata_valid,
  output logic                 o_wdata_ready,
  input  logic [SIZE_DATA-1:0] i_wdata,
  output logic                 o_rdata_valid,
  input  logic                 i_rdata_ready,
  output logic [SIZE_DATA-1:0] o_rdata,
  output logic                 o_ram_rd_en,
  output logic                 o_ram_wr_en,
  output logic [SIZE_ADDR-1:0] o_ram_addr,
  output logic [SIZE_DATA-1:0] o_ram_wdata,
  input  logic [SIZE_DATA-1:0] i_ram_rdata,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [FIFO_CNT_W:0] OCC_LIMIT = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

  state_t                r_state, w_state_next;
  logic [SIZE_ADDR-1:0]  r_addr, w_addr_next;
  logic [SIZE_LEN-1:0]   r_cnt, w_cnt_next;
  logic                  r_inflight;
  logic                  r_done, w_done_next;
  logic                  w_fifo_valid;
  logic                  w_pop;
  logic [FIFO_CNT_W-1:0] w_fifo_count;
  logic [FIFO_CNT_W:0]   w_occupancy;

  // Occupancy credits this cycle's pop so a draining consumer sustains one read per cycle.
  assign w_pop       = w_fifo_valid && i_rdata_ready;
  assign w_occupancy = {1'b0, w_fifo_count} - (FIFO_CNT_W + 1)'(w_pop)
                     + (FIFO_CNT_W + 1)'(r_inflight);

  burst_rd_fifo #(.SIZE_DATA(SIZE_DATA)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_inflight),
    .i_data  (i_ram_rdata),
    .i_pop   (w_pop),
    .o_data  (o_rdata),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_state_next  = r_state;
    w_addr_next   = r_addr;
    w_cnt_next    = r_cnt;
    w_done_next   = 1'b0;
    o_cmd_ready   = 1'b0;
    o_wdata_ready = 1'b0;
    o_ram_wr_en   = 1'b0;
    o_ram_rd_en   = 1'b0;
    o_ram_addr    = r_addr;
    o_ram_wdata   = i_wdata;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_addr_next  = i_cmd_addr;
          w_cnt_next   = i_cmd_len;
          w_state_next = i_cmd_wr ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        o_wdata_ready = 1'b1;
        o_ram_wr_en   = i_wdata_valid;
        if (i_wdata_valid) begin
          w_addr_next = r_addr + SIZE_ADDR'(1);
          w_cnt_next  = r_cnt - SIZE_LEN'(1);
          if (r_cnt == '0) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (w_occupancy < OCC_LIMIT) begin
          o_ram_rd_en = 1'b1;
          w_addr_next = r_addr + SIZE_ADDR'(1);
          w_cnt_next  = r_cnt - SIZE_LEN'(1);
          if (r_cnt == '0) begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_fifo_count == '0 && !r_inflight) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_addr     <= w_addr_next;
      r_cnt      <= w_cnt_next;
      r_inflight <= o_ram_rd_en;
      r_done     <= w_done_next;
    end
  end

  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = r_done;
  assign o_rdata_valid = w_fifo_valid;

endmodule
